// File: rtl/decode_pkg.sv
// Shared encodings, enums and the decoded-bundle struct for the RV32I subset decode stage.
package decode_pkg;

    localparam int DATA_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_B    = 2'b10
    } imm_sel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic              alu_src;
        alu_ctrl_t         alu_ctrl;
        logic              reg_write;
        logic              branch;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
    } decode_t;

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational I-type / B-type immediate extraction with sign extension.
module imm_gen
    import decode_pkg::*;
#(
    parameter int Data_Width  = 32,
    parameter int Instr_Width = 32
) (
    input  logic [Instr_Width-1:0] instr_i,
    input  imm_sel_t               sel_i,
    output logic [Data_Width-1:0]  imm_o
);

    // Opcode and register-index bits never contribute to an immediate.
    logic unused_bits_s;
    assign unused_bits_s = ^{instr_i[19:12], instr_i[6:0]};

    // Select and sign-extend the immediate for the instruction format.
    always_comb begin
        imm_o = {Data_Width{1'b0}};
        case (sel_i)
            IMM_I:    imm_o = {{(Data_Width-12){instr_i[31]}}, instr_i[31:20]};
            IMM_B:    imm_o = {{(Data_Width-13){instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_NONE: imm_o = {Data_Width{1'b0}};
            default:  imm_o = {Data_Width{1'b0}};
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// One-entry registered decode stage with valid/ready handshakes and a saturating illegal-word count.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int Data_Width  = DATA_W,
    parameter int Instr_Width = INSTR_W,
    parameter int Cnt_Width   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   inValid_i,
    output logic                   inReady_o,
    input  logic [Instr_Width-1:0] instr_i,
    output logic                   outValid_o,
    input  logic                   outReady_i,
    output logic [Data_Width-1:0]  ImmOp_o,
    output logic                   ALUSrc_o,
    output logic [2:0]             ALUctrl_o,
    output logic                   RegWrite_o,
    output logic                   Branch_o,
    output logic [4:0]             rs1_o,
    output logic [4:0]             rs2_o,
    output logic [4:0]             rd_o,
    output logic                   illegal_o,
    output logic [Cnt_Width-1:0]   illegalCount_o
);

    state_t                 state_q, state_d;
    decode_t                dec_q, dec_d, dec_ctrl_s;
    imm_sel_t               imm_sel_s;
    logic [Data_Width-1:0]  imm_s;
    logic [Cnt_Width-1:0]   cnt_q, cnt_d;
    logic                   reg_write_s;
    logic                   accept_s;

    assign outValid_o = (state_q == ST_FULL);
    assign inReady_o  = !rst_i && (!outValid_o || outReady_i);
    assign accept_s   = inValid_i && inReady_o;

    imm_gen #(
        .Data_Width  (Data_Width),
        .Instr_Width (Instr_Width)
    ) u_imm_gen (
        .instr_i (instr_i),
        .sel_i   (imm_sel_s),
        .imm_o   (imm_s)
    );

    // Classify the word and derive control fields; anything unrecognised is illegal with zeroed controls.
    always_comb begin
        dec_ctrl_s     = '0;
        imm_sel_s      = IMM_NONE;
        reg_write_s    = 1'b0;
        dec_ctrl_s.rs1 = instr_i[19:15];
        dec_ctrl_s.rs2 = instr_i[24:20];
        dec_ctrl_s.rd  = instr_i[11:7];
        case (instr_i[6:0])
            OP_IMM: begin
                if (instr_i[14:12] == F3_ADD) begin
                    dec_ctrl_s.alu_src = 1'b1;
                    reg_write_s        = 1'b1;
                    imm_sel_s          = IMM_I;
                end else begin
                    dec_ctrl_s.illegal = 1'b1;
                end
            end
            OP_REG: begin
                if (instr_i[14:12] == F3_ADD && instr_i[31:25] == F7_ADD) begin
                    reg_write_s = 1'b1;
                end else if (instr_i[14:12] == F3_ADD && instr_i[31:25] == F7_SUB) begin
                    reg_write_s         = 1'b1;
                    dec_ctrl_s.alu_ctrl = ALU_SUB;
                end else begin
                    dec_ctrl_s.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (instr_i[14:12] == F3_BNE) begin
                    dec_ctrl_s.alu_ctrl = ALU_SUB;
                    dec_ctrl_s.branch   = 1'b1;
                    imm_sel_s           = IMM_B;
                end else begin
                    dec_ctrl_s.illegal = 1'b1;
                end
            end
            default: dec_ctrl_s.illegal = 1'b1;
        endcase
        dec_ctrl_s.reg_write = reg_write_s && (instr_i[11:7] != 5'd0);
    end

    // Merge the immediate into the bundle captured on accept.
    always_comb begin
        dec_d     = dec_ctrl_s;
        dec_d.imm = imm_s;
    end

    // Next state and saturating counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: state_d = accept_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (outReady_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept_s && dec_d.illegal && (cnt_q != {Cnt_Width{1'b1}})) begin
            cnt_d = cnt_q + {{(Cnt_Width-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline register, state and counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            dec_q   <= '0;
            cnt_q   <= {Cnt_Width{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                dec_q <= dec_d;
            end else begin
                dec_q <= dec_q;
            end
        end
    end

    assign ImmOp_o        = dec_q.imm;
    assign ALUSrc_o       = dec_q.alu_src;
    assign ALUctrl_o      = dec_q.alu_ctrl;
    assign RegWrite_o     = dec_q.reg_write;
    assign Branch_o       = dec_q.branch;
    assign rs1_o          = dec_q.rs1;
    assign rs2_o          = dec_q.rs2;
    assign rd_o           = dec_q.rd;
    assign illegal_o      = dec_q.illegal;
    assign illegalCount_o = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed plus randomized bench for instr_decode_stage against a field-level reference model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] instr, ImmOp;
    logic        ALUSrc, RegWrite, Branch, illegal;
    logic [2:0]  ALUctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  illegalCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_imm;
    logic        m_alusrc, m_rw, m_br, m_ill;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_cnt;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .inValid_i      (inValid),
        .inReady_o      (inReady),
        .instr_i        (instr),
        .outValid_o     (outValid),
        .outReady_i     (outReady),
        .ImmOp_o        (ImmOp),
        .ALUSrc_o       (ALUSrc),
        .ALUctrl_o      (ALUctrl),
        .RegWrite_o     (RegWrite),
        .Branch_o       (Branch),
        .rs1_o          (rs1),
        .rs2_o          (rs2),
        .rd_o           (rd),
        .illegal_o      (illegal),
        .illegalCount_o (illegalCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_imm = 32'd0; m_alusrc = 1'b0; m_rw = 1'b0; m_br = 1'b0;
        m_ill = 1'b0; m_ctrl = 3'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_cnt = 0;
    endtask

    // Decode from the instruction-set rules using plain arithmetic.
    task automatic model_decode(input logic [31:0] w);
        int op, f3, f7, off;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        m_rs1 = w[19:15]; m_rs2 = w[24:20]; m_rd = w[11:7];
        m_imm = 32'd0; m_alusrc = 1'b0; m_rw = 1'b0; m_br = 1'b0; m_ctrl = 3'd0; m_ill = 1'b0;
        if (op == 'h13 && f3 == 0) begin
            m_imm = $signed(w) >>> 20;
            m_alusrc = 1'b1;
            m_rw = (m_rd != 5'd0);
        end else if (op == 'h33 && f3 == 0 && (f7 == 0 || f7 == 'h20)) begin
            m_ctrl = (f7 == 'h20) ? 3'd1 : 3'd0;
            m_rw = (m_rd != 5'd0);
        end else if (op == 'h63 && f3 == 1) begin
            off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            m_imm = 32'(off);
            m_ctrl = 3'd1;
            m_br = 1'b1;
        end else begin
            m_ill = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("outValid", {31'd0, outValid}, {31'd0, m_valid});
        chk("ImmOp", ImmOp, m_imm);
        chk("ALUSrc", {31'd0, ALUSrc}, {31'd0, m_alusrc});
        chk("ALUctrl", {29'd0, ALUctrl}, {29'd0, m_ctrl});
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
        chk("Branch", {31'd0, Branch}, {31'd0, m_br});
        chk("rs1", {27'd0, rs1}, {27'd0, m_rs1});
        chk("rs2", {27'd0, rs2}, {27'd0, m_rs2});
        chk("rd", {27'd0, rd}, {27'd0, m_rd});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("illegalCount", {24'd0, illegalCount}, 32'(m_cnt));
    endtask

    // One clock: drive, check readiness, advance the model, check outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] w, input logic r);
        logic exp_ready;
        inValid = v; instr = w; outReady = r;
        #1;
        exp_ready = !m_valid || r;
        chk("inReady", {31'd0, inReady}, {31'd0, exp_ready});
        @(posedge clk);
        if (v && exp_ready) begin
            m_valid = 1'b1;
            model_decode(w);
        end else if (r) begin
            m_valid = 1'b0;
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[14:0] = {w[14:12] & 3'b000, w[11:7], 7'b0010011};
            1: begin w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; w[14:12] = 3'b000; w[6:0] = 7'h33; end
            2: begin w[14:12] = 3'b001; w[6:0] = 7'h63; end
            3: ;
            default: begin w[31:25] = 7'h01; w[6:0] = 7'h33; end
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1; inValid = 1'b0; outReady = 1'b0; instr = 32'd0;
        model_reset();
        #2;
        chk("rst_inReady", {31'd0, inReady}, 32'd0);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        step(1'b1, 32'h00500093, 1'b1);
        chk("addi_imm", ImmOp, 32'h00000005);
        chk("addi_alusrc", {31'd0, ALUSrc}, 32'd1);
        chk("addi_rd", {27'd0, rd}, 32'd1);
        chk("addi_rw", {31'd0, RegWrite}, 32'd1);

        // Mid-clock reset while FULL, asserted with the consumer ready.
        outReady = 1'b1; inValid = 1'b1;
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_outValid", {31'd0, outValid}, 32'd0);
        chk("midrst_imm", ImmOp, 32'd0);
        chk("midrst_cnt", {24'd0, illegalCount}, 32'd0);
        chk("midrst_inReady", {31'd0, inReady}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_hold_inReady", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 32'hFFF00113, 1'b1);
        chk("neg1_imm", ImmOp, 32'hFFFFFFFF);
        step(1'b1, 32'h002081B3, 1'b1);
        chk("add_valid", {31'd0, outValid}, 32'd1);
        chk("add_alusrc", {31'd0, ALUSrc}, 32'd0);
        chk("add_rs1", {27'd0, rs1}, 32'd1);
        chk("add_rs2", {27'd0, rs2}, 32'd2);
        chk("add_rd", {27'd0, rd}, 32'd3);

        step(1'b1, 32'hFE009EE3, 1'b1);
        chk("bne_imm", ImmOp, 32'hFFFFFFFC);
        chk("bne_branch", {31'd0, Branch}, 32'd1);
        chk("bne_ctrl", {29'd0, ALUctrl}, 32'd1);
        chk("bne_rw", {31'd0, RegWrite}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00500093, 1'b0);
            chk("stall_imm", ImmOp, 32'hFFFFFFFC);
            chk("stall_inReady", {31'd0, inReady}, 32'd0);
        end
        step(1'b0, 32'h00000000, 1'b1);
        chk("drain_outValid", {31'd0, outValid}, 32'd0);

        for (int i = 0; i < 250; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 2) != 0));
        end

        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 32'hFFFFFFFF, 1'b1);
            chk("ill_flag", {31'd0, illegal}, 32'd1);
        end
        chk("ill_saturate", {24'd0, illegalCount}, 32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
